// File: rtl/spi_flash_read_responder.sv
// spi_flash_read_responder: oversampled SPI flash (cmd 0x03) read responder streaming bytes from a sync memory port
module spi_flash_read_responder #(
  parameter int MEM_DEPTH_BITWIDTH = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flash_clk,
  input  logic                          flash_cs,
  input  logic                          flash_mosi,
  output logic                          flash_miso,
  output logic                          mem_rd,
  output logic [MEM_DEPTH_BITWIDTH-1:0] mem_addr,
  input  logic [7:0]                    mem_data,
  output logic                          active,
  output logic                          cmd_error
);
  localparam int AW = MEM_DEPTH_BITWIDTH;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_q, scs_q, smosi_q;
  logic sclk_prev_q, scs_prev_q;
  logic [4:0] cnt_q, cnt_d;
  logic [6:0] cmd_q, cmd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0] tx_q, tx_d;
  logic load_q, miso_q, miso_d, rd_q, rd_d, err_q, err_d, active_q;
  logic sclk, scs, smosi, rise, fall, cs_fall;
  logic [7:0] cmd_byte;
  assign sclk = sclk_q[SYNC_STAGES-1];
  assign scs = scs_q[SYNC_STAGES-1];
  assign smosi = smosi_q[SYNC_STAGES-1];
  assign rise = sclk & ~sclk_prev_q;
  assign fall = ~sclk & sclk_prev_q;
  assign cs_fall = ~scs & scs_prev_q;
  assign cmd_byte = {cmd_q, smosi};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cmd_d = cmd_q;
    addr_d = addr_q;
    tx_d = tx_q;
    miso_d = miso_q;
    rd_d = 1'b0;
    err_d = err_q;
    case (state_q)
      IDLE: if (cs_fall) begin
        state_d = CMD;
        cnt_d = 5'd0;
        err_d = 1'b0;
      end
      CMD: if (rise) begin
        cmd_d = cmd_byte[6:0];
        cnt_d = cnt_q == 5'd7 ? 5'd0 : cnt_q + 5'd1;
        if (cnt_q == 5'd7) begin
          state_d = cmd_byte == 8'h03 ? ADDR : IGNORE;
          err_d = cmd_byte != 8'h03;
        end
      end
      ADDR: if (rise) begin
        addr_d = AW'({addr_q, smosi});
        cnt_d = cnt_q == 5'd23 ? 5'd0 : cnt_q + 5'd1;
        rd_d = cnt_q == 5'd23;
        state_d = cnt_q == 5'd23 ? DATA : ADDR;
      end
      DATA: begin
        if (fall) begin
          miso_d = tx_q[7];
          tx_d = {tx_q[6:0], 1'b0};
        end
        if (rise) begin
          cnt_d = cnt_q == 5'd7 ? 5'd0 : cnt_q + 5'd1;
          addr_d = cnt_q == 5'd7 ? addr_q + AW'(1) : addr_q;
          rd_d = cnt_q == 5'd7;
        end
        if (load_q) tx_d = mem_data;
      end
      default: miso_d = 1'b0;
    endcase
    // CS deassert overrides any edge seen in the same cycle
    if (scs) begin
      state_d = IDLE;
      cnt_d = 5'd0;
      miso_d = 1'b0;
      rd_d = 1'b0;
    end
  end
  // CS synchronizer resets to "low" so a CS already low at reset release never reads as a fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      scs_q <= '0;
      smosi_q <= '0;
      sclk_prev_q <= 1'b0;
      scs_prev_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= 5'd0;
      cmd_q <= 7'd0;
      addr_q <= '0;
      tx_q <= 8'd0;
      load_q <= 1'b0;
      miso_q <= 1'b0;
      rd_q <= 1'b0;
      err_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      sclk_q <= SYNC_STAGES'({sclk_q, flash_clk});
      scs_q <= SYNC_STAGES'({scs_q, flash_cs});
      smosi_q <= SYNC_STAGES'({smosi_q, flash_mosi});
      sclk_prev_q <= sclk;
      scs_prev_q <= scs;
      state_q <= state_d;
      cnt_q <= cnt_d;
      cmd_q <= cmd_d;
      addr_q <= addr_d;
      tx_q <= tx_d;
      load_q <= rd_q;
      miso_q <= miso_d;
      rd_q <= rd_d;
      err_q <= err_d;
      active_q <= state_d == DATA;
    end
  end
  assign flash_miso = miso_q;
  assign mem_rd = rd_q;
  assign mem_addr = addr_q;
  assign active = active_q;
  assign cmd_error = err_q;
endmodule

// File: tb/tb_spi_flash_read_responder.sv
// tb_spi_flash_read_responder: SPI master driving 12-bit and 4-bit address responders against a memory-array reference
module tb_spi_flash_read_responder;
  localparam int HALF = 6;
  logic clk = 1'b0, rst_n = 1'b0, flash_clk = 1'b0, flash_cs = 1'b0, flash_mosi = 1'b0;
  logic miso12, rd12, act12, err12, miso4, rd4, act4, err4;
  logic [11:0] addr12;
  logic [3:0] addr4;
  logic [7:0] data12, data4;
  logic [7:0] mem12 [4096];
  logic [7:0] mem4 [16];
  logic [11:0] rdq12 [$];
  logic [3:0] rdq4 [$];
  logic [7:0] got12 [16];
  logic [7:0] got4 [16];
  logic seen_miso;
  int nvec = 0, nerr = 0;
  spi_flash_read_responder u12 (
    .clk(clk), .rst_n(rst_n), .flash_clk(flash_clk), .flash_cs(flash_cs), .flash_mosi(flash_mosi),
    .flash_miso(miso12), .mem_rd(rd12), .mem_addr(addr12), .mem_data(data12),
    .active(act12), .cmd_error(err12));
  spi_flash_read_responder #(.MEM_DEPTH_BITWIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .flash_clk(flash_clk), .flash_cs(flash_cs), .flash_mosi(flash_mosi),
    .flash_miso(miso4), .mem_rd(rd4), .mem_addr(addr4), .mem_data(data4),
    .active(act4), .cmd_error(err4));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rd12) data12 <= mem12[addr12];
    if (rd4) data4 <= mem4[addr4];
  end
  always @(negedge clk) begin
    if (rd12) rdq12.push_back(addr12);
    if (rd4) rdq4.push_back(addr4);
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic spi_bit(input logic b, output logic s12, output logic s4);
    flash_mosi = b;
    repeat (HALF) @(negedge clk);
    flash_clk = 1'b1;
    s12 = miso12;
    s4 = miso4;
    seen_miso = seen_miso | s12 | s4;
    repeat (HALF) @(negedge clk);
    flash_clk = 1'b0;
  endtask
  task automatic spi_byte(input logic [7:0] o, output logic [7:0] i12, output logic [7:0] i4);
    logic s12, s4;
    for (int b = 7; b >= 0; b--) begin
      spi_bit(o[b], s12, s4);
      i12 = {i12[6:0], s12};
      i4 = {i4[6:0], s4};
    end
  endtask
  task automatic cs_low();
    flash_cs = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask
  task automatic cs_high();
    flash_cs = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask
  task automatic send_head(input logic [7:0] cmd, input logic [23:0] a);
    logic [7:0] d12, d4;
    spi_byte(cmd, d12, d4);
    spi_byte(a[23:16], d12, d4);
    spi_byte(a[15:8], d12, d4);
    spi_byte(a[7:0], d12, d4);
  endtask
  task automatic read_txn(input logic [7:0] cmd, input logic [23:0] a, input int n);
    rdq12.delete();
    rdq4.delete();
    seen_miso = 1'b0;
    cs_low();
    send_head(cmd, a);
    for (int k = 0; k < n; k++) begin
      spi_byte(8'($urandom), got12[k], got4[k]);
      if (k == 0) begin
        check("active_data", {31'd0, act12}, {31'd0, cmd == 8'h03});
        check("cmd_error_data", {31'd0, err4}, {31'd0, cmd != 8'h03});
      end
    end
    cs_high();
    check("active_idle", {31'd0, act12 | act4}, 32'd0);
  endtask
  task automatic check_read(input logic [23:0] a, input int n);
    for (int k = 0; k < n; k++) begin
      check("rx12", {24'd0, got12[k]}, {24'd0, mem12[(int'(a) + k) % 4096]});
      check("rx4", {24'd0, got4[k]}, {24'd0, mem4[(int'(a) + k) % 16]});
    end
    check("rd12_count", rdq12.size(), n + 1);
    check("rd4_count", rdq4.size(), n + 1);
    for (int k = 0; k < rdq12.size() && k <= n; k++)
      check("rd12_addr", {20'd0, rdq12[k]}, (int'(a) + k) % 4096);
    for (int k = 0; k < rdq4.size() && k <= n; k++)
      check("rd4_addr", {28'd0, rdq4[k]}, (int'(a) + k) % 16);
  endtask
  initial begin
    logic s12, s4;
    logic [7:0] d12, d4;
    logic [23:0] a;
    int n;
    for (int i = 0; i < 4096; i++) mem12[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) mem4[i] = 8'($urandom);
    mem12[0] = 8'h31; mem12[1] = 8'h32; mem12[2] = 8'h33; mem12[3] = 8'h34;
    mem12[4] = 8'h0a; mem12[5] = 8'h61; mem12[6] = 8'h62; mem12[7] = 8'h63;
    seen_miso = 1'b0;
    repeat (3) spi_bit(1'($urandom), s12, s4);
    check("rst_miso", {30'd0, miso12, miso4}, 32'd0);
    check("rst_mem_rd", {30'd0, rd12, rd4}, 32'd0);
    check("rst_active", {30'd0, act12, act4}, 32'd0);
    check("rst_cmd_error", {30'd0, err12, err4}, 32'd0);
    check("rst_mem_addr", {16'd0, addr12, addr4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rdq12.delete();
    rdq4.delete();
    repeat (40) spi_bit(1'($urandom), s12, s4);
    check("no_rd_after_rst", rdq12.size() + rdq4.size(), 0);
    check("no_active_after_rst", {30'd0, act12, act4}, 32'd0);
    cs_high();
    read_txn(8'h03, 24'h000000, 8);
    check_read(24'h000000, 8);
    check("word_at_0", {got12[3], got12[2], got12[1], got12[0]}, 32'h34333231);
    check("word_at_4", {got12[7], got12[6], got12[5], got12[4]}, 32'h6362610a);
    read_txn(8'h03, 24'h00000E, 4);
    check_read(24'h00000E, 4);
    check("wrap_addr2", {28'd0, rdq4[2]}, 32'h0);
    read_txn(8'h03, 24'hFF0005, 2);
    check_read(24'hFF0005, 2);
    check("upper_addr", {20'd0, rdq12[0]}, 32'h005);
    read_txn(8'h9F, 24'($urandom), 1);
    check("bad_miso", {31'd0, seen_miso}, 32'd0);
    check("bad_no_rd", rdq12.size() + rdq4.size(), 0);
    check("bad_cmd_error", {30'd0, err12, err4}, 32'h3);
    read_txn(8'h03, 24'h000010, 3);
    check_read(24'h000010, 3);
    check("err_cleared", {30'd0, err12, err4}, 32'd0);
    rdq12.delete();
    rdq4.delete();
    cs_low();
    send_head(8'h03, 24'h000001);
    spi_byte(8'($urandom), got12[0], got4[0]);
    repeat (5) spi_bit(1'($urandom), s12, s4);
    cs_high();
    check("abort_byte0", {24'd0, got12[0]}, {24'd0, mem12[1]});
    check("abort_rd", rdq12.size(), 2);
    repeat (50) @(negedge clk);
    check("abort_no_stray", rdq12.size() + rdq4.size(), 4);
    read_txn(8'h03, 24'h000004, 1);
    check_read(24'h000004, 1);
    check("after_abort", {24'd0, got12[0]}, 32'h0a);
    repeat (6) begin
      a = 24'($urandom);
      n = $urandom_range(1, 6);
      read_txn(8'h03, a, n);
      check_read(a, n);
    end
    cs_low();
    send_head(8'h03, 24'($urandom));
    repeat (3) spi_bit(1'($urandom), s12, s4);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {26'd0, miso12, miso4, rd12, rd4, act12, act4}, 32'd0);
    check("midrst_addr", {16'd0, addr12, addr4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rdq12.delete();
    rdq4.delete();
    repeat (40) spi_bit(1'($urandom), s12, s4);
    check("midrst_no_rd", rdq12.size() + rdq4.size(), 0);
    check("midrst_idle", {30'd0, act12, act4}, 32'd0);
    cs_high();
    a = 24'($urandom);
    read_txn(8'h03, a, 3);
    check_read(a, 3);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
